// File: rtl/lcdbl_pkg.sv
// Shared types and timing constants for the LCD backlight dimmer.
package lcdbl_pkg;

  typedef enum logic [1:0] {
    BL_INIT = 2'd0,
    BL_ON   = 2'd1,
    BL_DIM  = 2'd2,
    BL_OFF  = 2'd3
  } bl_state_e;

  localparam int unsigned CLK_HZ = 27_000_000;

  function automatic logic [31:0] ms_to_cycles(input int unsigned ms);
    logic [63:0] c;
    c = 64'(ms) * 64'(CLK_HZ / 1000);
    return c[31:0];
  endfunction

  localparam logic [31:0] TO_INIT_DEF = ms_to_cycles(3500);
  localparam logic [31:0] TO_DIM_DEF  = ms_to_cycles(45000);
  localparam logic [31:0] TO_OFF_DEF  = ms_to_cycles(10000);

endpackage

// File: rtl/lcdbl_dimmer_if.sv
// User-input path: raw IR word and buttons in, gated copies out to the CPU.
interface lcdbl_dimmer_if #(
  parameter int unsigned IR_W  = 24,
  parameter int unsigned N_BTN = 2
);
  logic [IR_W-1:0]  ir_in;
  logic [IR_W-1:0]  ir_out;
  logic [N_BTN-1:0] btn_in;
  logic [N_BTN-1:0] btn_out;

  modport master (output ir_in, output btn_in, input ir_out, input btn_out);
  modport slave  (input ir_in, input btn_in, output ir_out, output btn_out);
endinterface

// File: rtl/lcdbl_pwm_fader.sv
// Brightness level register with linear fade toward a target, plus the PWM generator.
module lcdbl_pwm_fader #(
  parameter int unsigned PWM_W    = 8,
  parameter int unsigned FADE_DIV = 105469
) (
  input  logic             clk27,
  input  logic             reset_n,
  input  logic [PWM_W-1:0] target,
  output logic             lcdbl_pwm,
  output logic [PWM_W-1:0] level
);

  localparam int unsigned      DIV_W    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [PWM_W-1:0] LVL_MAX  = '1;
  localparam logic [DIV_W-1:0] DIV_LOAD = (FADE_DIV > 0) ? DIV_W'(FADE_DIV - 1) : '0;

  logic [PWM_W-1:0] level_q, level_d;
  logic [PWM_W-1:0] target_l_q, target_l_d;
  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             pwm_q, pwm_d;

  always_comb begin
    level_d    = level_q;
    div_d      = div_q;
    target_l_d = target;
    pwm_cnt_d  = pwm_cnt_q + 1'b1;
    pwm_d      = (level_q == LVL_MAX) ? 1'b1 : (pwm_cnt_q < level_q);
    if (FADE_DIV == 0) begin
      level_d = target;
    end else if (target != target_l_q) begin
      // a new target restarts the step interval from a full period
      div_d = DIV_LOAD;
    end else if (div_q == '0) begin
      div_d = DIV_LOAD;
      if (level_q < target)
        level_d = level_q + 1'b1;
      else if (level_q > target)
        level_d = level_q - 1'b1;
    end else begin
      div_d = div_q - 1'b1;
    end
  end

  always_ff @(posedge clk27) begin
    if (!reset_n) begin
      level_q    <= LVL_MAX;
      target_l_q <= LVL_MAX;
      pwm_cnt_q  <= '0;
      div_q      <= DIV_LOAD;
      pwm_q      <= 1'b1;
    end else begin
      level_q    <= level_d;
      target_l_q <= target_l_d;
      pwm_cnt_q  <= pwm_cnt_d;
      div_q      <= div_d;
      pwm_q      <= pwm_d;
    end
  end

  assign lcdbl_pwm = pwm_q;
  assign level     = level_q;

endmodule

// File: rtl/lcdbl_dimmer.sv
// LCD backlight power manager: staged ON/DIM/OFF timeout, wake-input swallowing, faded PWM.
//  state   | meaning
//  BL_INIT | post-reset hold, full brightness, timeout not running
//  BL_ON   | full brightness, idle counter runs toward DIM
//  BL_DIM  | reduced brightness, idle counter runs toward OFF
//  BL_OFF  | backlight dark, user inputs blocked from the CPU
module lcdbl_dimmer
  import lcdbl_pkg::*;
#(
  parameter int unsigned N_BTN       = 2,
  parameter int unsigned IR_W        = 24,
  parameter int unsigned IR_CODE_W   = 16,
  parameter logic [31:0] TO_INIT     = TO_INIT_DEF,
  parameter logic [31:0] TO_DIM      = TO_DIM_DEF,
  parameter logic [31:0] TO_OFF      = TO_OFF_DEF,
  parameter int unsigned INIT_HOLD_W = 20,
  parameter int unsigned PWM_W       = 8,
  parameter int unsigned DIM_LEVEL   = 32,
  parameter int unsigned FADE_DIV    = 105469
) (
  input  logic           clk27,
  input  logic           reset_n,
  input  logic           lt_active,
  input  logic           en,
  input  logic           lcdbl_off,
  lcdbl_dimmer_if.slave  io,
  output logic           lcdbl_pwm,
  output logic [1:0]     bl_state
);

  localparam logic [PWM_W-1:0]       LVL_MAX   = '1;
  localparam logic [PWM_W-1:0]       LVL_DIM   = PWM_W'(DIM_LEVEL);
  localparam logic [INIT_HOLD_W-1:0] HOLD_ONES = '1;

  bl_state_e                 state_q, state_d;
  logic [31:0]               cnt_q, cnt_d;
  logic [INIT_HOLD_W-1:0]    hold_q, hold_d;
  logic                      swallow_q, swallow_d;
  logic                      lcdbl_off_l_q, lcdbl_off_l_d;
  logic [IR_CODE_W-1:0]      ir_code_q, ir_code_d;
  logic [IR_W-IR_CODE_W-1:0] ir_up_q, ir_up_d;
  logic [N_BTN-1:0]          btn_q, btn_d;
  logic [PWM_W-1:0]          target;
  logic [PWM_W-1:0]          level;
  logic                      in_active, toggle, tick_en, gate_open;

  assign in_active = (io.ir_in[IR_CODE_W-1:0] != '0) || !(&io.btn_in);
  assign toggle    = lcdbl_off ^ lcdbl_off_l_q;
  assign tick_en   = !lt_active && en;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    hold_d        = hold_q;
    swallow_d     = swallow_q && in_active;
    lcdbl_off_l_d = lcdbl_off;
    target        = LVL_MAX;
    case (state_q)
      BL_INIT: begin
        hold_d = (hold_q != '0) ? hold_q - 1'b1 : '0;
        if (hold_q <= INIT_HOLD_W'(1))
          state_d = BL_ON;
      end
      BL_ON, BL_DIM: begin
        if (state_q == BL_DIM)
          target = LVL_DIM;
        if (toggle) begin
          state_d   = BL_OFF;
          cnt_d     = '0;
          swallow_d = 1'b1;
        end else if (in_active) begin
          state_d = BL_ON;
          cnt_d   = TO_DIM;
        end else if (cnt_q == '0) begin
          state_d = (state_q == BL_ON) ? BL_DIM : BL_OFF;
          cnt_d   = (state_q == BL_ON) ? TO_OFF : '0;
        end else if (tick_en) begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      BL_OFF: begin
        target = '0;
        // the waking press is held back until it is released
        if (in_active && !swallow_q) begin
          state_d   = BL_ON;
          cnt_d     = TO_DIM;
          swallow_d = 1'b1;
        end
      end
      default: state_d = BL_INIT;
    endcase
  end

  always_comb begin
    gate_open = (state_d != BL_OFF) && !swallow_d;
    ir_code_d = gate_open ? io.ir_in[IR_CODE_W-1:0] : '0;
    btn_d     = gate_open ? io.btn_in : '1;
    ir_up_d   = io.ir_in[IR_W-1:IR_CODE_W];
  end

  always_ff @(posedge clk27) begin
    if (!reset_n) begin
      state_q       <= BL_INIT;
      cnt_q         <= TO_INIT;
      hold_q        <= HOLD_ONES;
      swallow_q     <= 1'b0;
      lcdbl_off_l_q <= lcdbl_off;
      ir_code_q     <= '0;
      btn_q         <= '1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hold_q        <= hold_d;
      swallow_q     <= swallow_d;
      lcdbl_off_l_q <= lcdbl_off_l_d;
      ir_code_q     <= ir_code_d;
      btn_q         <= btn_d;
    end
  end

  always_ff @(posedge clk27) begin
    ir_up_q <= ir_up_d;
  end

  lcdbl_pwm_fader #(
    .PWM_W    (PWM_W),
    .FADE_DIV (FADE_DIV)
  ) u_fader (
    .clk27     (clk27),
    .reset_n   (reset_n),
    .target    (target),
    .lcdbl_pwm (lcdbl_pwm),
    .level     (level)
  );

  // full-scale brightness must always come out as a solid-on backlight
  a_full_on: assert property (@(posedge clk27) disable iff (!reset_n)
                              (level == LVL_MAX) |=> lcdbl_pwm);

  assign io.ir_out  = {ir_up_q, ir_code_q};
  assign io.btn_out = btn_q;
  assign bl_state   = state_q;

endmodule

// File: tb/tb_lcdbl_dimmer.sv
// Directed scenarios for lcdbl_dimmer; expected outputs are queued by cycle and checked by a monitor.
module tb_lcdbl_dimmer;
  import lcdbl_pkg::*;

  localparam int K_STATE = 0, K_PWM = 1, K_IRC = 2, K_IRU = 3, K_BTN = 4, K_DUTY = 5;

  typedef struct {
    int          when;
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic       clk27     = 1'b0;
  logic       reset_n   = 1'b0;
  logic       lt_active = 1'b0;
  logic       en        = 1'b1;
  logic       lcdbl_off = 1'b0;
  logic       lcdbl_pwm;
  logic [1:0] bl_state;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic [15:0] hist = '0;

  lcdbl_dimmer_if #(.IR_W(24), .N_BTN(2)) bif ();

  lcdbl_dimmer #(
    .N_BTN(2), .IR_W(24), .IR_CODE_W(16),
    .TO_INIT(32'd20), .TO_DIM(32'd50), .TO_OFF(32'd30),
    .INIT_HOLD_W(4), .PWM_W(4), .DIM_LEVEL(4), .FADE_DIV(2)
  ) dut (
    .clk27     (clk27),
    .reset_n   (reset_n),
    .lt_active (lt_active),
    .en        (en),
    .lcdbl_off (lcdbl_off),
    .io        (bif.slave),
    .lcdbl_pwm (lcdbl_pwm),
    .bl_state  (bl_state)
  );

  always #5 clk27 = ~clk27;

  always @(posedge clk27) cyc <= cyc + 1;

  always @(posedge clk27) begin
    if (cyc > 5000) begin
      $display("FAIL watchdog: cycle %0d exceeded limit 5000", cyc);
      $fatal(1);
    end
  end

  task automatic exp_at(input int dly, input int kind, input logic [31:0] val, input string name);
    exp_t e;
    int   pos;
    e.when = cyc + dly;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    pos = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].when > e.when) begin
        pos = i;
        break;
      end
    end
    sb.insert(pos, e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk27);
    #1;
  endtask

  task automatic set_ir(input logic [15:0] code);
    bif.ir_in = {8'hA5, code};
  endtask

  // monitor: outputs are sampled on the falling edge, away from the active edge
  always @(negedge clk27) begin
    exp_t        e;
    logic [31:0] act;
    hist = {hist[14:0], lcdbl_pwm};
    while (sb.size() > 0 && sb[0].when <= cyc) begin
      e = sb.pop_front();
      checks++;
      case (e.kind)
        K_STATE: act = 32'(bl_state);
        K_PWM:   act = 32'(lcdbl_pwm);
        K_IRC:   act = 32'(bif.ir_out[15:0]);
        K_IRU:   act = 32'(bif.ir_out[23:16]);
        K_BTN:   act = 32'(bif.btn_out);
        default: act = 32'($countones(hist));
      endcase
      if (e.when < cyc) begin
        errors++;
        $display("FAIL %s: missed at cycle %0d (due %0d), required %0h", e.name, cyc, e.when, e.val);
      end else if (act !== e.val) begin
        errors++;
        $display("FAIL %s: cycle %0d got %0h required %0h", e.name, cyc, act, e.val);
      end
    end
  end

  initial begin
    int r, s, b, q, t, u, v, w, x;
    bit found;
    bif.ir_in  = {8'hA5, 16'h0000};
    bif.btn_in = 2'b11;

    // reset values
    step(3);
    exp_at(0, K_STATE, 0, "rst_state");
    exp_at(0, K_PWM, 1, "rst_pwm");
    exp_at(0, K_IRC, 0, "rst_ir_code");
    exp_at(0, K_BTN, 3, "rst_btn");
    exp_at(0, K_IRU, 32'hA5, "rst_ir_upper");

    // idle walk INIT -> ON -> DIM -> OFF
    reset_n = 1'b1;
    r = cyc;
    exp_at(14, K_STATE, 0, "init_last");
    exp_at(15, K_STATE, 1, "init_to_on");
    exp_at(20, K_PWM, 1, "on_pwm_full");
    exp_at(35, K_STATE, 1, "on_last");
    exp_at(36, K_STATE, 2, "on_to_dim");
    exp_at(50, K_IRU, 32'hA5, "ir_upper_dim");
    exp_at(66, K_STATE, 2, "dim_last");
    exp_at(67, K_STATE, 3, "dim_to_off");
    exp_at(80, K_PWM, 0, "off_pwm_zero");
    exp_at(95, K_DUTY, 0, "off_duty_zero");
    step(100);

    // wake from OFF by IR; the waking code is swallowed
    s = cyc;
    set_ir(16'h1234);
    exp_at(1, K_STATE, 1, "ir_wake_on");
    for (int k = 1; k <= 5; k++) exp_at(k, K_IRC, 0, "ir_wake_swallow");
    step(5);
    set_ir(16'h0000);
    step(2);
    set_ir(16'h00AA);
    exp_at(1, K_IRC, 32'h00AA, "ir_pass_after_wake");
    exp_at(1, K_IRU, 32'hA5, "ir_upper_pass");
    step(1);
    set_ir(16'h0000);
    exp_at(1, K_IRC, 0, "ir_release");
    exp_at(50, K_STATE, 1, "ir_reload_on_last");
    exp_at(51, K_STATE, 2, "ir_reload_to_dim");

    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      step(1);
      if (bl_state == 2'd2) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wait_dim: state %0d after 200 cycles, required 2", bl_state);
    end

    // button wake from DIM is passed through and reloads TO_DIM
    b = cyc;
    bif.btn_in = 2'b10;
    exp_at(1, K_STATE, 1, "dim_btn_on");
    exp_at(1, K_BTN, 2, "dim_btn_pass");
    step(1);
    bif.btn_in = 2'b11;
    exp_at(1, K_BTN, 3, "dim_btn_release");
    exp_at(50, K_STATE, 1, "btn_reload_on_last");
    exp_at(51, K_STATE, 2, "btn_reload_to_dim");
    step(51);

    // en=0 holds DIM; settled duty is DIM_LEVEL/16
    q = cyc;
    en = 1'b0;
    exp_at(48, K_DUTY, 4, "dim_duty_4of16");
    exp_at(58, K_STATE, 2, "en0_frozen_dim");
    step(60);
    t = cyc;
    en = 1'b1;
    exp_at(30, K_STATE, 2, "en_resume_last");
    exp_at(31, K_STATE, 3, "en_resume_off");
    step(32);

    // force-off with a button held; no wake until release and re-press
    u = cyc;
    bif.btn_in = 2'b10;
    exp_at(1, K_STATE, 1, "btn_wake_on");
    exp_at(1, K_BTN, 3, "btn_wake_swallow");
    step(3);
    bif.btn_in = 2'b11;
    step(2);
    v = cyc;
    bif.btn_in = 2'b01;
    exp_at(1, K_BTN, 1, "btn_pass_on");
    step(2);
    lcdbl_off = ~lcdbl_off;
    exp_at(1, K_STATE, 3, "force_off_state");
    exp_at(1, K_BTN, 3, "force_off_gate");
    exp_at(3, K_STATE, 3, "held_no_wake");
    exp_at(3, K_BTN, 3, "held_gate_closed");
    step(4);
    bif.btn_in = 2'b11;
    step(2);
    exp_at(0, K_STATE, 3, "off_after_release");
    bif.btn_in = 2'b10;
    exp_at(1, K_STATE, 1, "repress_wake_on");
    exp_at(1, K_BTN, 3, "repress_swallow");
    step(1);
    bif.btn_in = 2'b11;
    lt_active  = 1'b1;

    // lag tester freezes the idle counter in ON
    step(200);
    w = cyc;
    exp_at(0, K_STATE, 1, "lt_frozen_on");
    lt_active = 1'b0;
    exp_at(50, K_STATE, 1, "lt_resume_on_last");
    exp_at(51, K_STATE, 2, "lt_resume_to_dim");
    step(52);

    // toggle outranks simultaneous activity
    x = cyc;
    lcdbl_off = ~lcdbl_off;
    set_ir(16'h0055);
    exp_at(1, K_STATE, 3, "toggle_beats_active");
    exp_at(1, K_IRC, 0, "toggle_gate_closed");
    step(2);
    set_ir(16'h0000);

    // reset while fading down in OFF
    step(17);
    reset_n = 1'b0;
    set_ir(16'h0077);
    exp_at(1, K_STATE, 0, "rst_mid_state");
    exp_at(1, K_PWM, 1, "rst_mid_pwm");
    exp_at(2, K_PWM, 1, "rst_mid_pwm_hold");
    exp_at(1, K_IRC, 0, "rst_mid_ir_code");
    exp_at(1, K_IRU, 32'hA5, "rst_mid_ir_upper");
    exp_at(1, K_BTN, 3, "rst_mid_btn");
    step(3);
    set_ir(16'h0000);
    reset_n = 1'b1;
    step(5);

    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: never sampled (due %0d, now %0d), required %0h", e.name, e.when, cyc, e.val);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
